// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- definitions shared by the pipeline hazard controller and
// the mult/div busy timer.
//   md_state_t      : MDU busy-timer FSM states
//   REG_ZERO        : architectural zero register, never a hazard source
//   MD_LATENCY_DEF  : default MDU busy length in cycles
//   reg_match()     : true when a destination register feeds a source the
//                     instruction in ID actually reads
package pipeline_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_LATENCY_DEF = 32;

  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt
  );
    return (r != REG_ZERO) && ((uses_rs && (r == rs)) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer -- tracks how long the multi-cycle mult/div unit is busy.
//   clk        in  pipeline clock, rising edge
//   reset      in  asynchronous, active-high
//   MDStart_EX in  one-cycle pulse when an MDU op is in EX
//   MDBusy     out registered; high for MD_LATENCY cycles after a start
//
// state   | meaning
// MD_IDLE | MDU result valid, no op in flight
// MD_BUSY | op in flight, cnt_q counts remaining cycles down to 0
module md_busy_timer
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic MDStart_EX,
  output logic MDBusy
);

  localparam int               CNT_W    = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (MDStart_EX) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        // A start while busy should be blocked by the MDU stall; if one
        // slips through, treat it as a restart of the op.
        if (MDStart_EX) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign MDBusy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_control.sv
// hazard_control -- stall/flush controller for the five-stage pipeline.
// Detects the dependencies forwarding cannot cover, holds PC and IF/ID,
// bubbles ID/EX, flushes IF/ID on taken branches, and counts stall cycles.
//   clk, reset                  clock / async active-high reset
//   rs_ID, rt_ID, UsesRs_ID,
//   UsesRt_ID                   source operands of the ID instruction
//   Branch_ID, BranchTaken_ID   branch resolved in ID / redirect taken
//   HiLoRead_ID, MDOp_ID        mfhi/mflo or mult/div in ID
//   Rw_EX, Rw_MEM               destination registers in EX / MEM
//   RegWrite_EX, MemRead_EX,
//   MemRead_MEM, MDStart_EX     stage control bits
//   Stall_IF, Bubble_EX         hold front end / inject NOP (combinational)
//   Flush_IFID                  replace IF/ID with NOP (combinational)
//   MDBusy                      MDU result not yet valid (registered)
//   StallCount                  saturating stalled-cycle count (registered)
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY  = MD_LATENCY_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             rs_ID,
  input  logic [4:0]             rt_ID,
  input  logic                   UsesRs_ID,
  input  logic                   UsesRt_ID,
  input  logic                   Branch_ID,
  input  logic                   BranchTaken_ID,
  input  logic                   HiLoRead_ID,
  input  logic                   MDOp_ID,
  input  logic [4:0]             Rw_EX,
  input  logic [4:0]             Rw_MEM,
  input  logic                   RegWrite_EX,
  input  logic                   MemRead_EX,
  input  logic                   MemRead_MEM,
  input  logic                   MDStart_EX,
  output logic                   Stall_IF,
  output logic                   Bubble_EX,
  output logic                   Flush_IFID,
  output logic                   MDBusy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic match_ex, match_mem;
  logic load_use, br_ex, br_mem_load, md_hazard;
  logic stall;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_busy_timer #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy_timer (
    .clk       (clk),
    .reset     (reset),
    .MDStart_EX(MDStart_EX),
    .MDBusy    (MDBusy)
  );

  assign match_ex  = reg_match(Rw_EX,  rs_ID, rt_ID, UsesRs_ID, UsesRt_ID);
  assign match_mem = reg_match(Rw_MEM, rs_ID, rt_ID, UsesRs_ID, UsesRt_ID);

  assign load_use    = MemRead_EX && RegWrite_EX && match_ex;
  // Branches compare in ID, so even an ALU result in EX arrives too late.
  assign br_ex       = Branch_ID && RegWrite_EX && match_ex;
  assign br_mem_load = Branch_ID && MemRead_MEM && match_mem;
  // MDStart_EX covers the cycle before MDBusy is registered high.
  assign md_hazard   = (HiLoRead_ID || MDOp_ID) && (MDBusy || MDStart_EX);

  assign stall = load_use || br_ex || br_mem_load || md_hazard;

  assign Stall_IF   = stall;
  assign Bubble_EX  = stall;
  // A stalled branch is re-evaluated next cycle, so it must not flush yet.
  assign Flush_IFID = BranchTaken_ID && !stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

  localparam int MD_LAT = 4;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs_ID, rt_ID, Rw_EX, Rw_MEM;
  logic          UsesRs_ID, UsesRt_ID, Branch_ID, BranchTaken_ID;
  logic          HiLoRead_ID, MDOp_ID, RegWrite_EX, MemRead_EX, MemRead_MEM, MDStart_EX;
  logic          Stall_IF, Bubble_EX, Flush_IFID, MDBusy;
  logic [CW-1:0] StallCount;

  typedef struct {
    string         name;
    logic          stall;
    logic          flush;
    logic          busy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  hazard_control #(
    .MD_LATENCY (MD_LAT),
    .STALL_CNT_W(CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rs_ID         (rs_ID),
    .rt_ID         (rt_ID),
    .UsesRs_ID     (UsesRs_ID),
    .UsesRt_ID     (UsesRt_ID),
    .Branch_ID     (Branch_ID),
    .BranchTaken_ID(BranchTaken_ID),
    .HiLoRead_ID   (HiLoRead_ID),
    .MDOp_ID       (MDOp_ID),
    .Rw_EX         (Rw_EX),
    .Rw_MEM        (Rw_MEM),
    .RegWrite_EX   (RegWrite_EX),
    .MemRead_EX    (MemRead_EX),
    .MemRead_MEM   (MemRead_MEM),
    .MDStart_EX    (MDStart_EX),
    .Stall_IF      (Stall_IF),
    .Bubble_EX     (Bubble_EX),
    .Flush_IFID    (Flush_IFID),
    .MDBusy        (MDBusy),
    .StallCount    (StallCount)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs_ID = 0; rt_ID = 0; Rw_EX = 0; Rw_MEM = 0;
    UsesRs_ID = 0; UsesRt_ID = 0; Branch_ID = 0; BranchTaken_ID = 0;
    HiLoRead_ID = 0; MDOp_ID = 0; RegWrite_EX = 0; MemRead_EX = 0;
    MemRead_MEM = 0; MDStart_EX = 0;
  endtask

  // Advance to just after the next rising edge and start a fresh vector.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Push the expected response for the vector now on the inputs. The stall
  // count seen this cycle reflects only earlier cycles' stalls.
  task automatic expect_out(input string nm, input logic st, input logic fl, input logic bz);
    exp_t e;
    e.name  = nm;
    e.stall = st;
    e.flush = fl;
    e.busy  = bz;
    e.cnt   = CW'(exp_cnt);
    q.push_back(e);
    if (st && exp_cnt < (1 << CW) - 1) exp_cnt++;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the
  // oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".Stall_IF"},   int'(Stall_IF),   int'(e.stall));
        chk({e.name, ".Bubble_EX"},  int'(Bubble_EX),  int'(e.stall));
        chk({e.name, ".Flush_IFID"}, int'(Flush_IFID), int'(e.flush));
        chk({e.name, ".MDBusy"},     int'(MDBusy),     int'(e.busy));
        chk({e.name, ".StallCount"}, int'(StallCount), int'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    #2;

    // Reset state
    cyc(); expect_out("reset", 0, 0, 0);
    cyc(); reset = 1'b0; expect_out("idle", 0, 0, 0);

    // Load-use on rs: one stall, then the load sits in MEM and clears it
    cyc(); MemRead_EX = 1; RegWrite_EX = 1; Rw_EX = 5; UsesRs_ID = 1; rs_ID = 5;
    expect_out("lu_stall", 1, 0, 0);
    cyc(); MemRead_MEM = 1; Rw_MEM = 5; UsesRs_ID = 1; rs_ID = 5;
    expect_out("lu_release", 0, 0, 0);

    // Zero register and unused rt never stall
    cyc(); MemRead_EX = 1; RegWrite_EX = 1; Rw_EX = 0; UsesRs_ID = 1; rs_ID = 0;
    expect_out("zero_reg", 0, 0, 0);
    cyc(); MemRead_EX = 1; RegWrite_EX = 1; Rw_EX = 5; UsesRs_ID = 1; rs_ID = 3; rt_ID = 5;
    expect_out("rt_unused", 0, 0, 0);
    cyc(); MemRead_EX = 1; RegWrite_EX = 1; Rw_EX = 5; UsesRs_ID = 1; rs_ID = 3;
    UsesRt_ID = 1; rt_ID = 5;
    expect_out("rt_used", 1, 0, 0);

    // ALU result in EX feeding a taken branch: stall wins, then flush
    cyc(); Branch_ID = 1; BranchTaken_ID = 1; UsesRs_ID = 1; rs_ID = 8;
    RegWrite_EX = 1; Rw_EX = 8;
    expect_out("br_alu_stall", 1, 0, 0);
    cyc(); Branch_ID = 1; BranchTaken_ID = 1; UsesRs_ID = 1; rs_ID = 8;
    expect_out("br_alu_flush", 0, 1, 0);

    // Load feeding a branch: load-use cycle, MEM-load cycle, then flush
    cyc(); Branch_ID = 1; BranchTaken_ID = 1; UsesRs_ID = 1; rs_ID = 8;
    MemRead_EX = 1; RegWrite_EX = 1; Rw_EX = 8;
    expect_out("br_ld_c1", 1, 0, 0);
    cyc(); Branch_ID = 1; BranchTaken_ID = 1; UsesRs_ID = 1; rs_ID = 8;
    MemRead_MEM = 1; Rw_MEM = 8;
    expect_out("br_ld_c2", 1, 0, 0);
    cyc(); Branch_ID = 1; BranchTaken_ID = 1; UsesRs_ID = 1; rs_ID = 8;
    expect_out("br_ld_c3", 0, 1, 0);

    // MDU: start at cycle 0, mfhi waiting in ID through cycle 4
    cyc(); MDStart_EX = 1; HiLoRead_ID = 1; expect_out("md_c0", 1, 0, 0);
    cyc(); HiLoRead_ID = 1; expect_out("md_c1", 1, 0, 1);
    cyc(); HiLoRead_ID = 1; expect_out("md_c2", 1, 0, 1);
    cyc(); MDOp_ID = 1;     expect_out("md_c3", 1, 0, 1);
    cyc(); HiLoRead_ID = 1; expect_out("md_c4", 1, 0, 1);
    cyc(); HiLoRead_ID = 1; expect_out("md_c5", 0, 0, 0);

    // Reset asserted between edges while busy
    cyc(); MDStart_EX = 1; expect_out("rst_c0", 0, 0, 0);
    cyc(); expect_out("rst_c1", 0, 0, 1);
    cyc(); reset = 1'b1; exp_cnt = 0; expect_out("rst_async", 0, 0, 0);
    cyc(); reset = 1'b0; expect_out("rst_after", 0, 0, 0);
    cyc(); expect_out("rst_no_restart", 0, 0, 0);

    // Saturation: 20 stalled cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      cyc(); MemRead_EX = 1; RegWrite_EX = 1; Rw_EX = 9; UsesRt_ID = 1; rt_ID = 9;
      expect_out($sformatf("sat_%0d", i), 1, 0, 0);
    end
    cyc(); expect_out("sat_hold", 0, 0, 0);
    cyc(); expect_out("sat_final", 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
